isp8_alu_seq: RTL and testbench

//  Parametrised, handshaked ALU for the next-generation Mico8-class core: same add/sub/logic/rotate
//  op set as the current datapath ALU, generalised to DATA_WIDTH bits, with registered outputs and
//  a multi-cycle shift-add multiplier. Sits between register-file read and write-back; the

---
 rtl/isp8_alu_seq.sv | 177 +++++++++++++++++
 tb/tb_isp8_alu_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/isp8_alu_seq.sv
// Handshaked Mico8-class ALU: single-cycle add/sub/logic/rotate ops with registered outputs,
// plus an optional DATA_WIDTH-step shift-add unsigned multiplier.
module isp8_alu_seq #(
  parameter int DATA_WIDTH  = 8,
  parameter bit MUL_EN      = 1'b1,
  parameter     FAMILY_NAME = "XO"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic                  imm_sel,
  input  logic [DATA_WIDTH-1:0] opa,
  input  logic [DATA_WIDTH-1:0] opb,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  carry_in,
  output logic                  out_valid,
  output logic                  out_wr,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  carry_out,
  output logic                  zero_out,
  output logic                  busy
);

  localparam int EXT_W = DATA_WIDTH + 1;
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_ADDC = 4'h1, OP_SUB  = 4'h2, OP_SUBC = 4'h3,
    OP_CMP  = 4'h4, OP_MOV  = 4'h5, OP_AND  = 4'h6, OP_OR   = 4'h7,
    OP_XOR  = 4'h8, OP_TEST = 4'h9, OP_ROR  = 4'hA, OP_RORC = 4'hB,
    OP_ROL  = 4'hC, OP_ROLC = 4'hD, OP_MUL  = 4'hE, OP_RSVD = 4'hF
  } op_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e                  state_q, state_d;
  op_e                     op_dec;
  logic [DATA_WIDTH-1:0]   b_opnd;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_c;
  logic                    alu_wr;
  logic [EXT_W-1:0]        add_ext;
  logic [EXT_W-1:0]        sub_ext;
  logic [EXT_W-1:0]        step_sum;
  logic                    accept;
  logic                    is_mul;
  logic                    mul_last;
  logic [CNT_W-1:0]        step_cnt;
  logic [DATA_WIDTH-1:0]   mcand_q;
  logic [2*DATA_WIDTH-1:0] prod_q;
  logic [2*DATA_WIDTH-1:0] prod_next;

  assign op_dec   = op_e'(op);
  assign b_opnd   = imm_sel ? imm : opb;
  assign is_mul   = MUL_EN && (op_dec == OP_MUL);
  assign accept   = in_valid && in_ready;
  assign busy     = ~in_ready;
  assign mul_last = (state_q == S_MUL) && (step_cnt == CNT_W'(DATA_WIDTH - 1));

  // Bit DATA_WIDTH of the extended sum is the carry; of the difference it is the borrow.
  assign add_ext = {1'b0, opa} + {1'b0, b_opnd} + EXT_W'((op_dec == OP_ADDC) && carry_in);
  assign sub_ext = {1'b0, opa} - {1'b0, b_opnd} - EXT_W'((op_dec == OP_SUBC) && carry_in);

  // One shift-add step: add the multiplicand into the high half when the current multiplier
  // bit (prod_q[0]) is set, then shift the whole product right by one.
  assign step_sum  = {1'b0, prod_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                   + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_next = {step_sum, prod_q[DATA_WIDTH-1:1]};

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = carry_in;
    alu_wr  = 1'b1;
    case (op_dec)
      OP_ADD, OP_ADDC: {alu_c, alu_res} = add_ext;
      OP_SUB, OP_SUBC: {alu_c, alu_res} = sub_ext;
      OP_CMP: begin
        {alu_c, alu_res} = sub_ext;
        alu_wr           = 1'b0;
      end
      OP_MOV:  alu_res = b_opnd;
      OP_AND:  alu_res = opa & b_opnd;
      OP_OR:   alu_res = opa | b_opnd;
      OP_XOR:  alu_res = opa ^ b_opnd;
      OP_TEST: begin
        alu_res = opa & b_opnd;
        alu_wr  = 1'b0;
      end
      OP_ROR:  alu_res = {b_opnd[0], b_opnd[DATA_WIDTH-1:1]};
      OP_RORC: begin
        alu_res = {carry_in, b_opnd[DATA_WIDTH-1:1]};
        alu_c   = b_opnd[0];
      end
      OP_ROL:  alu_res = {b_opnd[DATA_WIDTH-2:0], b_opnd[DATA_WIDTH-1]};
      OP_ROLC: begin
        alu_res = {b_opnd[DATA_WIDTH-2:0], carry_in};
        alu_c   = b_opnd[DATA_WIDTH-1];
      end
      default: begin
        // Reserved (F, or E without a multiplier): all ones, no write-back.
        alu_res = '1;
        alu_c   = 1'b0;
        alu_wr  = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (accept && is_mul) state_d = S_MUL;
      end
      S_MUL: begin
        if (mul_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the multiplier working registers are reset too, keeping X out of the step adder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      step_cnt <= '0;
    end else if (accept && is_mul) begin
      mcand_q  <= opa;
      prod_q   <= {{DATA_WIDTH{1'b0}}, b_opnd};
      step_cnt <= '0;
    end else if (state_q == S_MUL) begin
      prod_q   <= prod_next;
      step_cnt <= step_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_wr    <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      carry_out <= 1'b0;
      zero_out  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_mul) begin
        out_valid <= 1'b1;
        out_wr    <= alu_wr;
        result    <= alu_res;
        result_hi <= '0;
        carry_out <= alu_c;
        zero_out  <= (alu_res == '0);
      end else if (mul_last) begin
        out_valid <= 1'b1;
        out_wr    <= 1'b1;
        result    <= prod_next[DATA_WIDTH-1:0];
        result_hi <= prod_next[2*DATA_WIDTH-1:DATA_WIDTH];
        carry_out <= |prod_next[2*DATA_WIDTH-1:DATA_WIDTH];
        zero_out  <= (prod_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_isp8_alu_seq.sv
// Randomised self-checking bench for isp8_alu_seq: an 8-bit instance with the multiplier and a
// 16-bit instance without it, both checked against an arithmetic reference model.
module tb_isp8_alu_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-bit instance, multiplier enabled
  logic       v8, isel8, cin8;
  logic [3:0] op8;
  logic [7:0] a8, b8, i8;
  logic       rdy8, ov8, wr8, co8, z8, busy8;
  logic [7:0] r8, rh8;

  // 16-bit instance, multiplier disabled
  logic        v16, isel16, cin16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, i16;
  logic        rdy16, ov16, wr16, co16, z16, busy16;
  logic [15:0] r16, rh16;

  isp8_alu_seq #(.DATA_WIDTH(8), .MUL_EN(1'b1), .FAMILY_NAME("XO")) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .op(op8), .imm_sel(isel8),
    .opa(a8), .opb(b8), .imm(i8), .carry_in(cin8), .out_valid(ov8), .out_wr(wr8),
    .result(r8), .result_hi(rh8), .carry_out(co8), .zero_out(z8), .busy(busy8)
  );

  isp8_alu_seq #(.DATA_WIDTH(16), .MUL_EN(1'b0), .FAMILY_NAME("XO")) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .op(op16), .imm_sel(isel16),
    .opa(a16), .opb(b16), .imm(i16), .carry_in(cin16), .out_valid(ov16), .out_wr(wr16),
    .result(r16), .result_hi(rh16), .carry_out(co16), .zero_out(z16), .busy(busy16)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    longint unsigned res;
    longint unsigned hi;
    bit              c;
    bit              z;
    bit              wr;
    int              lat;
  } exp_t;

  // Reference: op semantics from plain arithmetic on w-bit values.
  function automatic exp_t model(input int w, input bit mul_en, input logic [3:0] op,
                                 input longint unsigned a, input longint unsigned b,
                                 input bit cin);
    longint unsigned m, full;
    exp_t e;
    m = (64'd1 << w) - 64'd1;
    full = 0;
    e.res = 0; e.hi = 0; e.c = cin; e.wr = 1'b1; e.lat = 1;
    case (op)
      4'h0: begin full = a + b; e.res = full & m; e.c = (full > m); end
      4'h1: begin full = a + b + longint'(cin); e.res = full & m; e.c = (full > m); end
      4'h2: begin e.res = (a - b) & m; e.c = (a < b); end
      4'h3: begin e.res = (a - b - longint'(cin)) & m; e.c = (a < b + longint'(cin)); end
      4'h4: begin e.res = (a - b) & m; e.c = (a < b); e.wr = 1'b0; end
      4'h5: e.res = b;
      4'h6: e.res = a & b;
      4'h7: e.res = a | b;
      4'h8: e.res = a ^ b;
      4'h9: begin e.res = a & b; e.wr = 1'b0; end
      4'hA: e.res = (b >> 1) | ((b & 64'd1) << (w - 1));
      4'hB: begin e.res = (b >> 1) | (longint'(cin) << (w - 1)); e.c = b[0]; end
      4'hC: e.res = ((b << 1) & m) | (b >> (w - 1));
      4'hD: begin e.res = ((b << 1) & m) | longint'(cin); e.c = ((b >> (w - 1)) & 64'd1) != 0; end
      4'hE: begin
        if (mul_en) begin
          full  = a * b;
          e.res = full & m;
          e.hi  = full >> w;
          e.c   = (e.hi != 0);
          e.lat = w + 1;
        end else begin
          e.res = m; e.c = 1'b0; e.wr = 1'b0;
        end
      end
      default: begin e.res = m; e.c = 1'b0; e.wr = 1'b0; end
    endcase
    e.z = (op == 4'hE && mul_en) ? (full == 0) : (e.res == 0);
    return e;
  endfunction

  // Issue one op on the 8-bit instance, spray ignored in_valid pulses while busy, and check
  // latency, handshake and all result fields.
  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input bit cin);
    exp_t e;
    bit   isel;
    int   lat;
    e    = model(8, 1'b1, op, 64'(a), 64'(b), cin);
    isel = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("ov8_idle_low", 64'(ov8), 64'd0);
    check("rdy8_idle", 64'(rdy8), 64'd1);
    v8 = 1'b1; op8 = op; a8 = a; cin8 = cin; isel8 = isel;
    b8 = isel ? 8'($urandom) : b;
    i8 = isel ? b : 8'($urandom);
    lat = 0;
    for (int k = 1; k <= e.lat + 2; k++) begin
      @(negedge clk);
      if (ov8) begin
        lat = k;
        break;
      end
      check("busy8_state", 64'({rdy8, busy8}), 64'd1);
      v8    = 1'($urandom_range(0, 1));
      op8   = 4'($urandom_range(0, 15));
      a8    = 8'($urandom);
      b8    = 8'($urandom);
      i8    = 8'($urandom);
      cin8  = 1'($urandom_range(0, 1));
      isel8 = 1'($urandom_range(0, 1));
    end
    v8 = 1'b0;
    check($sformatf("lat8_op%0h", op), 64'(lat), 64'(e.lat));
    check("rdy8_done", 64'(rdy8), 64'd1);
    check($sformatf("res8_op%0h", op), 64'(r8), e.res);
    check($sformatf("hi8_op%0h", op), 64'(rh8), e.hi);
    check($sformatf("c8_op%0h", op), 64'(co8), 64'(e.c));
    check($sformatf("z8_op%0h", op), 64'(z8), 64'(e.z));
    check($sformatf("wr8_op%0h", op), 64'(wr8), 64'(e.wr));
  endtask

  // Back-to-back stream on the 16-bit instance; force_op < 0 picks random ops.
  task automatic stream16(input int n, input int force_op);
    exp_t q[$];
    exp_t e;
    logic [3:0]  op;
    logic [15:0] a, b;
    bit          cin, isel;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = q.pop_front();
        check("ov16_stream", 64'(ov16), 64'd1);
        check("res16", 64'(r16), e.res);
        check("hi16", 64'(rh16), e.hi);
        check("c16", 64'(co16), 64'(e.c));
        check("z16", 64'(z16), 64'(e.z));
        check("wr16", 64'(wr16), 64'(e.wr));
      end else begin
        check("ov16_idle_low", 64'(ov16), 64'd0);
      end
      check("rdy16", 64'({rdy16, busy16}), 64'd2);
      if (i < n) begin
        op   = (force_op < 0) ? 4'($urandom_range(0, 15)) : 4'(force_op);
        a    = 16'($urandom);
        b    = 16'($urandom);
        cin  = 1'($urandom_range(0, 1));
        isel = 1'($urandom_range(0, 1));
        v16 = 1'b1; op16 = op; a16 = a; cin16 = cin; isel16 = isel;
        b16 = isel ? 16'($urandom) : b;
        i16 = isel ? b : 16'($urandom);
        q.push_back(model(16, 1'b0, op, 64'(a), 64'(b), cin));
      end else begin
        v16 = 1'b0;
      end
    end
    @(negedge clk);
    check("ov16_pulse_end", 64'(ov16), 64'd0);
  endtask

  task automatic check_reset8(input string tag);
    check({tag, "_ov"}, 64'(ov8), 64'd0);
    check({tag, "_wr"}, 64'(wr8), 64'd0);
    check({tag, "_res"}, 64'(r8), 64'd0);
    check({tag, "_hi"}, 64'(rh8), 64'd0);
    check({tag, "_c"}, 64'(co8), 64'd0);
    check({tag, "_z"}, 64'(z8), 64'd0);
    check({tag, "_rdy_busy"}, 64'({rdy8, busy8}), 64'd2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    rst = 1'b1;
    v8 = 1'b0; isel8 = 1'b0; cin8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; i8 = '0;
    v16 = 1'b0; isel16 = 1'b0; cin16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; i16 = '0;
    repeat (2) @(negedge clk);
    check_reset8("rst8");
    check("rst16_ov", 64'(ov16), 64'd0);
    check("rst16_res", 64'(r16), 64'd0);
    rst = 1'b0;

    // Directed corner vectors
    run8(4'h0, 8'hF0, 8'h20, 1'b0);
    run8(4'h3, 8'h05, 8'h05, 1'b1);
    run8(4'h4, 8'h33, 8'h33, 1'b0);
    run8(4'h9, 8'h0F, 8'hF0, 1'b1);
    run8(4'hB, 8'h5A, 8'h01, 1'b0);
    run8(4'hC, 8'h5A, 8'h80, 1'b1);
    run8(4'hF, 8'h12, 8'h34, 1'b1);
    run8(4'hE, 8'hFF, 8'hFF, 1'b0);
    run8(4'hE, 8'h00, 8'hA5, 1'b1);
    run8(4'hE, 8'h0D, 8'h0B, 1'b0);

    // Reset in the 4th multiply cycle aborts it with no out_valid
    @(negedge clk);
    v8 = 1'b1; op8 = 4'hE; a8 = 8'hFF; b8 = 8'hFF; isel8 = 1'b0; cin8 = 1'b0;
    @(negedge clk);
    v8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset8("midmul_rst");
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ov8) stray++;
    end
    check("midmul_no_ov", 64'(stray), 64'd0);
    run8(4'h0, 8'h01, 8'h01, 1'b0);

    // Randomised ops on the 8-bit instance
    for (int n = 0; n < 60; n++)
      run8(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    // 16-bit instance: reserved MUL opcode, 8 back-to-back ADDs, random stream
    stream16(1, 14);
    stream16(8, 0);
    stream16(40, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
